anomaly_alarm_controller: RTL and testbench

Downstream stage of the anomaly detection system. Consumes the 1-bit anomaly_detected output of the isolation-tree state machine, counts distinct anomaly events in fixed time windows, and raises a latched alarm plus a one-cycle interrupt pulse when the count reaches a threshold. The alarm is held until the host acknowledges it. A holdoff period then runs before monitoring resumes. A saturating lifetime event counter is exposed for diagnostics.

---
 rtl/anomaly_alarm_controller.sv | 145 ++++++++++++++
 tb/tb_anomaly_alarm_controller.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/anomaly_alarm_controller.sv
// Anomaly alarm controller: counts rising-edge anomaly events per time window,
// latches an alarm with a one-cycle irq on threshold, then holds off after host ack.
module anomaly_alarm_controller #(
    parameter int unsigned WINDOW_CYCLES  = 256,
    parameter int unsigned THRESHOLD      = 4,
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned HOLDOFF_CYCLES = 64,
    parameter int unsigned TOTAL_W        = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               anomaly_detected,
    input  logic               alarm_ack,
    output logic               alarm,
    output logic               alarm_irq,
    output logic [CNT_W-1:0]   window_count,
    output logic [TOTAL_W-1:0] total_count,
    output logic               busy
);

    localparam int unsigned WcycW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int unsigned HoldW = $clog2(HOLDOFF_CYCLES + 1);

    localparam logic [WcycW-1:0] WcycLast = WcycW'(WINDOW_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] Thresh   = CNT_W'(THRESHOLD);

    typedef enum logic [1:0] {StIdle, StMonitor, StAlarm, StHoldoff} state_e;

    state_e             state_q, state_d;
    logic               anom_q;
    logic               irq_q, irq_d;
    logic [WcycW-1:0]   wcyc_q, wcyc_d;
    logic [HoldW-1:0]   hold_q, hold_d;
    logic [CNT_W-1:0]   win_q, win_d;
    logic [TOTAL_W-1:0] total_q, total_d;

    logic               evt;
    logic               wrap;
    logic [CNT_W-1:0]   win_base;
    logic [CNT_W-1:0]   win_inc;

    // A level held high is one event: only the 0->1 transition counts.
    assign evt  = anomaly_detected & ~anom_q;
    assign wrap = (wcyc_q == WcycLast);

    always_comb begin
        total_d = total_q;
        if (evt && (total_q != {TOTAL_W{1'b1}})) begin
            total_d = total_q + TOTAL_W'(1);
        end
    end

    // An event in the wrap cycle lands in the fresh window.
    always_comb begin
        win_base = wrap ? '0 : win_q;
        win_inc  = win_base;
        if (evt && (win_base != {CNT_W{1'b1}})) begin
            win_inc = win_base + CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        wcyc_d  = wcyc_q;
        hold_d  = hold_q;
        win_d   = win_q;
        irq_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                wcyc_d = '0;
                win_d  = '0;
                hold_d = '0;
                if (enable) begin
                    state_d = StMonitor;
                end
            end
            StMonitor: begin
                wcyc_d = wrap ? '0 : wcyc_q + WcycW'(1);
                win_d  = win_inc;
                if (evt && (win_inc >= Thresh)) begin
                    state_d = StAlarm;
                    irq_d   = 1'b1;
                end
            end
            StAlarm: begin
                if (alarm_ack) begin
                    state_d = StHoldoff;
                    hold_d  = '0;
                end
            end
            StHoldoff: begin
                if (hold_q == HoldLast) begin
                    state_d = StMonitor;
                    hold_d  = '0;
                    wcyc_d  = '0;
                    win_d   = '0;
                end else begin
                    hold_d = hold_q + HoldW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Disable wins over any same-cycle threshold crossing or ack.
        if (!enable) begin
            state_d = StIdle;
            wcyc_d  = '0;
            win_d   = '0;
            hold_d  = '0;
            irq_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            anom_q  <= 1'b0;
            irq_q   <= 1'b0;
            wcyc_q  <= '0;
            hold_q  <= '0;
            win_q   <= '0;
            total_q <= '0;
        end else begin
            state_q <= state_d;
            anom_q  <= anomaly_detected;
            irq_q   <= irq_d;
            wcyc_q  <= wcyc_d;
            hold_q  <= hold_d;
            win_q   <= win_d;
            total_q <= total_d;
        end
    end

    assign alarm        = (state_q == StAlarm);
    assign alarm_irq    = irq_q;
    assign busy         = (state_q != StIdle);
    assign window_count = win_q;
    assign total_count  = total_q;

endmodule

// File: tb/tb_anomaly_alarm_controller.sv
// Scoreboard bench for anomaly_alarm_controller: directed stimulus queues expected
// outputs, a negedge monitor pops and compares them against the DUT.
module tb_anomaly_alarm_controller;

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned TOTAL_W = 16;

    logic               clk;
    logic               reset;
    logic               enable;
    logic               anomaly_detected;
    logic               alarm_ack;
    logic               alarm;
    logic               alarm_irq;
    logic [CNT_W-1:0]   window_count;
    logic [TOTAL_W-1:0] total_count;
    logic               busy;

    anomaly_alarm_controller #(
        .WINDOW_CYCLES  (16),
        .THRESHOLD      (4),
        .CNT_W          (CNT_W),
        .HOLDOFF_CYCLES (64),
        .TOTAL_W        (TOTAL_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .anomaly_detected (anomaly_detected),
        .alarm_ack        (alarm_ack),
        .alarm            (alarm),
        .alarm_irq        (alarm_irq),
        .window_count     (window_count),
        .total_count      (total_count),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        alarm;
        logic        irq;
        logic        busy;
        bit          chk_wc;
        logic [31:0] wc;
        logic [31:0] tc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic cmp(input string name, input string field,
                       input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s.%s: got %0d, expected %0d", name, field, got, want);
        end
    endtask

    // Monitor: compares every pending expectation at the falling edge.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp(e.name, "alarm", {31'd0, alarm}, {31'd0, e.alarm});
            cmp(e.name, "alarm_irq", {31'd0, alarm_irq}, {31'd0, e.irq});
            cmp(e.name, "busy", {31'd0, busy}, {31'd0, e.busy});
            cmp(e.name, "total_count", {16'd0, total_count}, e.tc);
            if (e.chk_wc) begin
                cmp(e.name, "window_count", {24'd0, window_count}, e.wc);
            end
        end
    end

    task automatic expect_out(input string name, input logic a, input logic irq,
                              input logic b, input bit chk_wc, input int wc, input int tc);
        exp_t e;
        e.name   = name;
        e.alarm  = a;
        e.irq    = irq;
        e.busy   = b;
        e.chk_wc = chk_wc;
        e.wc     = wc;
        e.tc     = tc;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Raise anomaly for one cycle; returns just after the edge that samples the event.
    task automatic pulse_ev();
        anomaly_detected = 1'b1;
        tick(1);
        anomaly_detected = 1'b0;
    endtask

    task automatic restart();
        enable = 1'b0;
        tick(1);
        enable = 1'b1;
        tick(1);
    endtask

    initial begin
        reset            = 1'b0;
        enable           = 1'b0;
        anomaly_detected = 1'b0;
        alarm_ack        = 1'b0;
        tick(3);
        expect_out("reset", 0, 0, 0, 1, 0, 0);
        reset = 1'b1;
        tick(1);

        // Idle with enable low: total counts, nothing else moves.
        repeat (3) begin
            pulse_ev();
            tick(1);
        end
        expect_out("idle", 0, 0, 0, 1, 0, 3);

        // Threshold hit from a fresh window.
        enable = 1'b1;
        tick(1);
        repeat (3) begin
            pulse_ev();
            tick(1);
        end
        expect_out("thr_pre", 0, 0, 1, 1, 3, 6);
        pulse_ev();
        expect_out("thr_hit", 1, 1, 1, 1, 4, 7);
        tick(1);
        expect_out("thr_irq_drop", 1, 0, 1, 1, 4, 7);
        tick(2);
        expect_out("alarm_hold", 1, 0, 1, 1, 4, 7);

        // Enable dropped in ALARM.
        enable = 1'b0;
        tick(1);
        expect_out("dis_alarm", 0, 0, 0, 1, 0, 7);

        // Window wrap: fourth event lands in the wrap cycle.
        enable = 1'b1;
        tick(1);
        repeat (3) begin
            pulse_ev();
            tick(1);
        end
        tick(9);
        expect_out("wrap_pre", 0, 0, 1, 1, 3, 10);
        pulse_ev();
        expect_out("wrap_evt", 0, 0, 1, 1, 1, 11);

        // Level held high counts once.
        restart();
        anomaly_detected = 1'b1;
        tick(10);
        expect_out("level_10", 0, 0, 1, 1, 1, 12);
        tick(40);
        expect_out("level_50", 0, 0, 1, 1, 0, 12);
        anomaly_detected = 1'b0;

        // Ack in the first ALARM cycle, then holdoff.
        restart();
        repeat (3) begin
            pulse_ev();
            tick(1);
        end
        pulse_ev();
        alarm_ack = 1'b1;
        expect_out("ack_hit", 1, 1, 1, 1, 4, 16);
        tick(1);
        alarm_ack = 1'b0;
        expect_out("holdoff_entry", 0, 0, 1, 0, 0, 16);
        repeat (4) begin
            pulse_ev();
            tick(1);
        end
        expect_out("holdoff_evts", 0, 0, 1, 0, 0, 20);
        tick(55);
        pulse_ev();
        expect_out("holdoff_last", 0, 0, 1, 1, 0, 21);
        tick(1);
        repeat (3) begin
            pulse_ev();
            tick(1);
        end
        pulse_ev();
        expect_out("resume_hit", 1, 1, 1, 1, 4, 25);

        // Asynchronous reset mid-cycle in MONITOR.
        alarm_ack = 1'b1;
        tick(1);
        alarm_ack = 1'b0;
        expect_out("ack_late", 0, 0, 1, 0, 0, 25);
        restart();
        repeat (2) begin
            pulse_ev();
            tick(1);
        end
        expect_out("pre_reset", 0, 0, 1, 1, 2, 27);
        tick(1);
        #2;
        reset = 1'b0;
        expect_out("async_reset", 0, 0, 0, 1, 0, 0);
        tick(2);
        reset = 1'b1;
        tick(2);

        for (int i = 0; i < 100 && exp_q.size() > 0; i++) begin
            tick(1);
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
